// File: rtl/wb_lsu_master_if.sv
// Wishbone classic bus bundle shared by the LSU master and its slave.
interface wb_lsu_master_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/wb_lsu_master.sv
// Core load/store unit to Wishbone master: lane steering, load extension,
// misalignment detection and an ack timeout, one transfer at a time.
module wb_lsu_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic                   we_req_i,
  input  logic [1:0]             size_i,
  input  logic                   unsigned_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [31:0]            rdata_o,
  wb_lsu_master_if.master        wb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] sel;
    case (size)
      2'b00:   sel = 4'b0001 << lo;
      2'b01:   sel = lo[1] ? 4'b1100 : 4'b0011;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  lo,
                                              input logic [31:0] raw);
    logic [31:0] sh;
    logic [31:0] r;
    sh = raw >> {lo, 3'b000};
    case (size)
      2'b00:   r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   r = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic for the IDLE/BUS/RESP sequencer.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (is_misaligned(size_i, addr_i[1:0])) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = BUS;
            cyc_d      = 1'b1;
            stb_d      = 1'b1;
            we_d       = we_req_i;
            sel_d      = lane_sel(size_i, addr_i[1:0]);
            adr_d      = {addr_i[31:2], 2'b00};
            dat_d      = lane_data(size_i, wdata_i);
            cnt_d      = 8'd0;
            size_d     = size_i;
            unsigned_d = unsigned_i;
            lo_d       = addr_i[1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // Ack wins over a timeout landing in the same cycle.
        if (wb.ack_i) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = load_extend(size_q, unsigned_q, lo_q, wb.dat_i);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == TIMEOUT_M1) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      adr_q      <= 32'h0000_0000;
      dat_q      <= 32'h0000_0000;
      cnt_q      <= 8'd0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lo_q       <= 2'b00;
      rdata_q    <= 32'h0000_0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      lo_q       <= lo_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = stb_q;
  assign wb.we_o  = we_q;
  assign wb.sel_o = sel_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master, built with TIMEOUT=4 so the timeout path is short.
module tb_wb_lsu_master;
  logic        clk_i;
  logic        rst_ni;
  logic        req_i;
  logic        we_req_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_lsu_master_if bus ();

  wb_lsu_master #(.TIMEOUT(4)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .we_req_i   (we_req_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rdata_o    (rdata_o),
    .wb         (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_i      = 1'b1;
    we_req_i   = we;
    size_i     = sz;
    unsigned_i = uns;
    addr_i     = a;
    wdata_i    = wd;
  endtask

  initial begin
    rst_ni = 1'b1; req_i = 1'b0; we_req_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; bus.dat_i = 32'h0; bus.ack_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_cyc",   {31'h0, bus.cyc_o}, 32'h0);
    check("rst_stb",   {31'h0, bus.stb_o}, 32'h0);
    check("rst_busy",  {31'h0, busy_o},    32'h0);
    check("rst_done",  {31'h0, done_o},    32'h0);
    check("rst_sel",   {28'h0, bus.sel_o}, 32'h0);
    check("rst_adr",   bus.adr_o,          32'h0);
    check("rst_rdata", rdata_o,            32'h0);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;

    // Ack while idle must be ignored
    bus.ack_i = 1'b1;
    tick();
    check("idle_ack_busy", {31'h0, busy_o}, 32'h0);
    check("idle_ack_done", {31'h0, done_o}, 32'h0);
    bus.ack_i = 1'b0;

    // Word load, slave acks one cycle after stb
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    tick();
    req_i = 1'b0;
    check("wl_cyc",  {31'h0, bus.cyc_o}, 32'h1);
    check("wl_stb",  {31'h0, bus.stb_o}, 32'h1);
    check("wl_busy", {31'h0, busy_o},    32'h1);
    check("wl_sel",  {28'h0, bus.sel_o}, 32'hF);
    check("wl_adr",  bus.adr_o,          32'h10);
    check("wl_we",   {31'h0, bus.we_o},  32'h0);
    tick();
    check("wl_cyc_hold", {31'h0, bus.cyc_o}, 32'h1);
    check("wl_no_done",  {31'h0, done_o},    32'h0);
    bus.dat_i = 32'hDEAD_BEEF; bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("wl_done",  {31'h0, done_o},    32'h1);
    check("wl_err",   {31'h0, err_o},     32'h0);
    check("wl_rdata", rdata_o,            32'hDEAD_BEEF);
    check("wl_cyc0",  {31'h0, bus.cyc_o}, 32'h0);
    tick();
    check("wl_done_pulse", {31'h0, done_o}, 32'h0);
    check("wl_idle_busy",  {31'h0, busy_o}, 32'h0);

    // Byte store to lane 3
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5);
    tick();
    req_i = 1'b0;
    check("bs_sel", {28'h0, bus.sel_o}, 32'h8);
    check("bs_dat", bus.dat_o,          32'hA5A5_A5A5);
    check("bs_we",  {31'h0, bus.we_o},  32'h1);
    check("bs_adr", bus.adr_o,          32'h10);
    bus.dat_i = 32'h1111_1111; bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("bs_done",  {31'h0, done_o}, 32'h1);
    check("bs_err",   {31'h0, err_o},  32'h0);
    check("bs_rdata", rdata_o,         32'hDEAD_BEEF);
    tick();

    // Signed half load from upper half
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0);
    tick();
    req_i = 1'b0;
    check("hs_sel", {28'h0, bus.sel_o}, 32'hC);
    check("hs_adr", bus.adr_o,          32'h4);
    bus.dat_i = 32'h8001_0000; bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("hs_done",  {31'h0, done_o}, 32'h1);
    check("hs_rdata", rdata_o,         32'hFFFF_8001);
    tick();

    // Unsigned half load, same data
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0);
    tick();
    req_i = 1'b0;
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("hu_rdata", rdata_o, 32'h0000_8001);
    tick();

    // Signed byte load from lane 1
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0);
    tick();
    req_i = 1'b0;
    check("bl_sel", {28'h0, bus.sel_o}, 32'h2);
    bus.dat_i = 32'h0000_8000; bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("bl_rdata", rdata_o, 32'hFFFF_FF80);
    tick();

    // Misaligned word load: error pulse, no bus cycle
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
    tick();
    req_i = 1'b0;
    check("mis_cyc",  {31'h0, bus.cyc_o}, 32'h0);
    check("mis_done", {31'h0, done_o},    32'h1);
    check("mis_err",  {31'h0, err_o},     32'h1);
    tick();
    check("mis_done_off", {31'h0, done_o},    32'h0);
    check("mis_err_off",  {31'h0, err_o},     32'h0);
    check("mis_cyc_off",  {31'h0, bus.cyc_o}, 32'h0);

    // Timeout: no ack, cycle held for 4 BUS cycles
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    tick();
    req_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("to_cyc_%0d", i), {31'h0, bus.cyc_o}, 32'h1);
      check($sformatf("to_nodone_%0d", i), {31'h0, done_o}, 32'h0);
    end
    tick();
    check("to_cyc_drop", {31'h0, bus.cyc_o}, 32'h0);
    check("to_done",     {31'h0, done_o},    32'h1);
    check("to_err",      {31'h0, err_o},     32'h1);
    check("to_rdata",    rdata_o,            32'hFFFF_FF80);
    tick();

    // Normal word load after the timeout
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0);
    tick();
    req_i = 1'b0;
    bus.dat_i = 32'h1234_5678; bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("post_to_done",  {31'h0, done_o}, 32'h1);
    check("post_to_err",   {31'h0, err_o},  32'h0);
    check("post_to_rdata", rdata_o,         32'h1234_5678);
    tick();

    // Ack in the timeout cycle wins; a request while busy is ignored
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0048, 32'h0);
    tick();
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0080, 32'h0);
    tick();
    req_i = 1'b0;
    check("busy_req_adr", bus.adr_o,         32'h48);
    check("busy_req_we",  {31'h0, bus.we_o}, 32'h0);
    tick();
    tick();
    bus.dat_i = 32'hCAFE_F00D; bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("race_done",  {31'h0, done_o}, 32'h1);
    check("race_err",   {31'h0, err_o},  32'h0);
    check("race_rdata", rdata_o,         32'hCAFE_F00D);
    tick();
    check("race_idle", {31'h0, busy_o}, 32'h0);

    // Reset in the middle of a bus cycle
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0);
    tick();
    req_i = 1'b0;
    check("mr_cyc_pre", {31'h0, bus.cyc_o}, 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    check("mr_cyc",   {31'h0, bus.cyc_o}, 32'h0);
    check("mr_busy",  {31'h0, busy_o},    32'h0);
    check("mr_adr",   bus.adr_o,          32'h0);
    check("mr_rdata", rdata_o,            32'h0);
    bus.ack_i = 1'b1;
    tick();
    check("mr_no_done", {31'h0, done_o}, 32'h0);
    bus.ack_i = 1'b0;
    #2 rst_ni = 1'b1;
    tick();
    check("mr_idle_done", {31'h0, done_o},    32'h0);
    check("mr_idle_cyc",  {31'h0, bus.cyc_o}, 32'h0);

    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    tick();
    req_i = 1'b0;
    check("ar_cyc", {31'h0, bus.cyc_o}, 32'h1);
    bus.dat_i = 32'h0BAD_CAFE; bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("ar_done",  {31'h0, done_o}, 32'h1);
    check("ar_err",   {31'h0, err_o},  32'h0);
    check("ar_rdata", rdata_o,         32'h0BAD_CAFE);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
